// File: rtl/midi_fifo_if.sv
// Bundle of FIFO handshake/data signals between producer/consumer and midi_fifo.
// master: drives clr/strobes/data_i and sees status; slave: the FIFO side.
interface midi_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              clr;
    logic              stb_wr;
    logic [DATA_W-1:0] data_i;
    logic              stb_rd;
    logic [DATA_W-1:0] data_o;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              ovf;
    logic              udf;

    modport master (
        output clr, stb_wr, data_i, stb_rd,
        input  data_o, empty, full, almost_full, count, ovf, udf
    );

    modport slave (
        input  clr, stb_wr, data_i, stb_rd,
        output data_o, empty, full, almost_full, count, ovf, udf
    );
endinterface

// File: rtl/midi_fifo.sv
// Synchronous FWFT FIFO buffering MIDI bytes ahead of the UART transmitter.
// Ports: clk, reset (async, active-high), bus (midi_fifo_if.slave):
//   clr/stb_wr/data_i/stb_rd in; data_o/empty/full/almost_full/count/ovf/udf out.
module midi_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic        clk,
    input  logic        reset,
    midi_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AFULL = CW'(AFULL_LVL);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_udf;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == LP_DEPTH);
    // A pop at full frees a slot in the same edge, so the write still lands.
    assign w_rd_acc = bus.stb_rd & ~w_empty & ~bus.clr;
    assign w_wr_acc = bus.stb_wr & (~w_full | w_rd_acc) & ~bus.clr;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_tail] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (bus.clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_rd_acc) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.stb_wr & ~w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            // Read on empty is flagged even when a write lands that edge.
            if (bus.stb_rd & w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.data_o      = w_empty ? '0 : r_mem[r_head];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= LP_AFULL);
    assign bus.count       = r_count;
    assign bus.ovf         = r_ovf;
    assign bus.udf         = r_udf;
endmodule

// File: tb/tb_midi_fifo.sv
// Self-checking bench for midi_fifo: queue scoreboard plus status model.
// Ports: none (top-level bench).
module tb_midi_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AFL    = DEPTH - 1;

    logic clk;
    logic reset;

    midi_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    midi_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .AFULL_LVL(AFL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] sb[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    int   max_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] hd;
        int n;
        n  = sb.size();
        hd = (n == 0) ? '0 : sb[0];
        check({tag, ".count"}, 32'(bus.count), 32'(n));
        check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        check({tag, ".afull"}, 32'(bus.almost_full), 32'(n >= AFL));
        check({tag, ".data_o"}, 32'(bus.data_o), 32'(hd));
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
        check({tag, ".udf"}, 32'(bus.udf), 32'(m_udf));
    endtask

    task automatic cycle(input string tag, input logic wr, input logic rd,
                         input logic [DATA_W-1:0] d, input logic cl);
        logic rd_acc;
        logic wr_acc;
        logic [DATA_W-1:0] exp_rd;
        @(negedge clk);
        bus.stb_wr = wr;
        bus.stb_rd = rd;
        bus.data_i = d;
        bus.clr    = cl;
        rd_acc = rd && !cl && sb.size() > 0;
        wr_acc = wr && !cl && (sb.size() < DEPTH || rd_acc);
        // Consumer samples the head in the same cycle it strobes.
        if (rd_acc) begin
            exp_rd = sb.pop_front();
            check({tag, ".rd"}, 32'(bus.data_o), 32'(exp_rd));
        end
        if (cl) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr && !wr_acc) m_ovf = 1'b1;
            if (rd && !rd_acc) m_udf = 1'b1;
            if (wr_acc) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        if (sb.size() > max_cnt) max_cnt = sb.size();
        check_state(tag);
        bus.stb_wr = 1'b0;
        bus.stb_rd = 1'b0;
        bus.clr    = 1'b0;
    endtask

    logic [DATA_W-1:0] fill_pat [4];
    logic [DATA_W-1:0] k;

    initial begin
        fill_pat[0] = 8'h90;
        fill_pat[1] = 8'h3C;
        fill_pat[2] = 8'h40;
        fill_pat[3] = 8'h80;
        bus.clr    = 1'b0;
        bus.stb_wr = 1'b0;
        bus.stb_rd = 1'b0;
        bus.data_i = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) cycle("fill", 1, 0, fill_pat[i], 0);
        for (int i = 0; i < 4; i++) cycle("drain", 0, 1, '0, 0);

        for (int i = 0; i < 4; i++) cycle("refill", 1, 0, fill_pat[i], 0);
        cycle("ovf_drop", 1, 0, 8'hAA, 0);
        cycle("full_rw", 1, 1, 8'hBB, 0);
        for (int i = 0; i < 4; i++) cycle("drain2", 0, 1, '0, 0);

        cycle("clr1", 0, 0, '0, 1);
        cycle("udf_rd", 0, 1, '0, 0);
        cycle("empty_rw", 1, 1, 8'h55, 0);
        cycle("udf_drain", 0, 1, '0, 0);

        cycle("clr2", 0, 0, '0, 1);
        max_cnt = 0;
        k = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cycle("wrap_w", 1, 0, k, 0);
            k++;
            cycle("wrap_w", 1, 0, k, 0);
            k++;
            cycle("wrap_r", 0, 1, '0, 0);
            cycle("wrap_r", 0, 1, '0, 0);
        end
        check("wrap.maxcnt", 32'(max_cnt <= 2), 32'd1);

        for (int i = 0; i < 4; i++) cycle("pre_clr", 1, 0, fill_pat[i], 0);
        cycle("pre_clr_ovf", 1, 0, 8'hAA, 0);
        cycle("pre_clr_rd", 0, 1, '0, 0);
        cycle("clr_wr", 1, 0, 8'h77, 1);

        cycle("pre_rst", 1, 0, 8'h11, 0);
        cycle("pre_rst", 1, 0, 8'h22, 0);
        #2;
        reset = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_state("async_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle("post_rst", 1, 0, 8'h12, 0);
        cycle("post_rst_rd", 0, 1, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
